// File: rtl/ifetch_queue_if.sv
// Bus bundle between the instruction-fetch queue, the instruction memory
// and the decode stage. The fetch queue is the master of this bundle.
interface ifetch_queue_if #(
  parameter int AW    = 14,
  parameter int DW    = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // instruction memory port A
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;

  // fetch control from the back end
  logic          halt;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;

  // decode-side handshake
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_line;
  logic [AW-1:0] out_pc;
  logic [CW-1:0] out_count;

  modport master (
    output imem_addr,
    input  imem_data,
    input  halt,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_line,
    output out_pc,
    output out_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output halt,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_line,
    input  out_pc,
    input  out_count
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the PC, addresses the instruction
// memory, and queues each returned line together with its PC in a small
// FIFO whose head is presented to decode without an output register.
// A redirect flushes the queue and reloads the PC; halt stops fetching
// while the queue keeps draining.
module ifetch_queue #(
  parameter int            AW       = 14,
  parameter int            DW       = 64,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  ifetch_queue_if.master  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;

  // architectural state
  logic [AW-1:0] pc_q,     pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [EW-1:0] mem_q [DEPTH];

  // storage write port, computed alongside the pointer update
  logic          wr_en_s;
  logic [EW-1:0] entry_d;

  // handshake qualifiers
  logic          empty_s;
  logic          has_room_s;
  logic          pop_s;
  logic          push_s;

  // Handshake qualification: a pop needs a valid head; a push needs no
  // redirect, no halt, and either free space or a slot freed by this pop.
  always_comb begin
    empty_s    = (count_q == {CW{1'b0}});
    has_room_s = (count_q < CW'(DEPTH));
    pop_s      = (!empty_s) & bus.out_ready;
    push_s     = (!bus.redirect_valid) & (!bus.halt) & (has_room_s | pop_s);
  end

  // Next-state computation; a redirect overrides every other update.
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_en_s  = 1'b0;
    entry_d  = {pc_q, bus.imem_data};

    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc;
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_en_s  = 1'b1;
        pc_d     = pc_q + AW'(1);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_en_s  = 1'b0;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // PC, pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Line storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end

  // Outputs come straight from the registers so the head has no latency.
  always_comb begin
    bus.imem_addr = pc_q;
    bus.out_valid = !empty_s;
    bus.out_line  = mem_q[rd_ptr_q][DW-1:0];
    bus.out_pc    = mem_q[rd_ptr_q][EW-1:DW];
    bus.out_count = count_q;
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed test of ifetch_queue: streaming fetch, full/back-pressure,
// redirect flush, PC wrap, halt drain/resume and asynchronous reset.
module tb_ifetch_queue;

  localparam int AW    = 14;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  ifetch_queue_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

  ifetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(14'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory content: a pattern unique to every address.
  function automatic logic [63:0] line_of(input logic [13:0] a);
    line_of = {16'hF00D, 2'b00, a, 16'h1234 ^ {2'b00, a}, 2'b11, ~a};
  endfunction

  assign bus.imem_data = line_of(bus.imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [13:0] pc, input int cnt);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1'b1));
    chk({tag, "_pc"},    64'(bus.out_pc),    64'(pc));
    chk({tag, "_line"},  bus.out_line,       line_of(pc));
    chk({tag, "_count"}, 64'(bus.out_count), 64'(cnt));
  endtask

  task automatic chk_empty(input string tag, input logic [13:0] addr);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1'b0));
    chk({tag, "_count"}, 64'(bus.out_count), 64'(0));
    chk({tag, "_addr"},  64'(bus.imem_addr), 64'(addr));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.halt = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 14'h0000;
    bus.out_ready = 1'b1;

    // ---- reset state
    #1;
    chk_empty("rst0", 14'h0000);
    chk("rst0_line", bus.out_line, 64'h0);
    chk("rst0_pc", 64'(bus.out_pc), 64'h0);
    #2 rst = 1'b0;

    // ---- streaming with out_ready=1
    step();
    chk_head("stream1", 14'd0, 1);
    chk("stream1_addr", 64'(bus.imem_addr), 64'd1);
    for (int k = 2; k <= 3; k++) begin
      step();
      chk_head("stream", 14'(k - 1), 1);
      chk("stream_addr", 64'(bus.imem_addr), 64'(k));
    end

    // ---- back-pressure from a fresh reset
    #3 rst = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    chk_empty("bp_rst", 14'h0000);
    #2 rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_head("bp_fill", 14'd0, (k < 4) ? k : 4);
      chk("bp_addr", 64'(bus.imem_addr), 64'((k < 4) ? k : 4));
    end
    bus.out_ready = 1'b1;
    step();
    chk_head("bp_poppush", 14'd1, 4);
    chk("bp_poppush_addr", 64'(bus.imem_addr), 64'd5);
    // drain under halt: line 4 must have been captured at the tail
    bus.halt = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk_head("bp_drain", 14'(k), 5 - k);
    end
    step();
    chk_empty("bp_drained", 14'd5);

    // ---- fill then redirect to 0x0100
    bus.halt = 1'b0;
    bus.out_ready = 1'b0;
    repeat (4) step();
    chk_head("rd_full", 14'd5, 4);
    chk("rd_full_addr", 64'(bus.imem_addr), 64'd9);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 14'h0100;
    step();
    chk_empty("rd_flush", 14'h0100);
    bus.redirect_valid = 1'b0;
    step();
    chk_head("rd_first", 14'h0100, 1);
    chk("rd_first_addr", 64'(bus.imem_addr), 64'h0101);

    // ---- PC wrap at the top of the address space
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 14'h3FFE;
    step();
    chk_empty("wrap_flush", 14'h3FFE);
    bus.redirect_valid = 1'b0;
    step();
    chk_head("wrap0", 14'h3FFE, 1);
    step();
    chk_head("wrap1", 14'h3FFF, 1);
    chk("wrap1_addr", 64'(bus.imem_addr), 64'h0000);
    step();
    chk_head("wrap2", 14'h0000, 1);
    step();
    chk_head("wrap3", 14'h0001, 1);
    chk("wrap3_addr", 64'(bus.imem_addr), 64'h0002);

    // ---- halt with three lines queued, then resume
    bus.out_ready = 1'b0;
    repeat (2) step();
    chk_head("halt_q3", 14'h0001, 3);
    chk("halt_q3_addr", 64'(bus.imem_addr), 64'h0004);
    bus.halt = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk_head("halt_pop1", 14'h0002, 2);
    step();
    chk_head("halt_pop2", 14'h0003, 1);
    step();
    chk_empty("halt_pop3", 14'h0004);
    step();
    chk_empty("halt_idle", 14'h0004);
    bus.halt = 1'b0;
    step();
    chk_head("halt_resume", 14'h0004, 1);
    chk("halt_resume_addr", 64'(bus.imem_addr), 64'h0005);

    // ---- redirect together with halt still flushes and loads the PC
    bus.out_ready = 1'b0;
    step();
    bus.halt = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 14'h0200;
    step();
    chk_empty("rdh_flush", 14'h0200);
    bus.redirect_valid = 1'b0;
    step();
    chk_empty("rdh_hold", 14'h0200);
    bus.halt = 1'b0;
    step();
    chk_head("rdh_resume", 14'h0200, 1);

    // ---- asynchronous reset mid-stream
    bus.out_ready = 1'b1;
    step();
    chk_head("ar_pre", 14'h0201, 1);
    #3 rst = 1'b1;
    #1;
    chk_empty("ar_now", 14'h0000);
    chk("ar_line", bus.out_line, 64'h0);
    chk("ar_pc", 64'(bus.out_pc), 64'h0);
    #2 rst = 1'b0;
    step();
    chk_head("ar_restart0", 14'h0000, 1);
    chk("ar_restart0_addr", 64'(bus.imem_addr), 64'h0001);
    step();
    chk_head("ar_restart1", 14'h0001, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the 64-bit instruction memory.
- Holds the program counter and drives the memory's 14-bit line address.
- Captures each returned 64-bit line, tagged with its PC, into a small FIFO.
- Presents lines to decode with a valid/ready handshake; supports halt and branch-redirect flush.

Parameters:
- AW, 14, line-address width; matches the instruction memory address port.
- DW, 64, line width; matches the instruction memory data port.
- DEPTH, 4, FIFO entries; must be a power of two, minimum 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  AW  line address to instruction memory port A; equals the PC register.
- imem_data  input  DW  line returned by instruction memory; combinational read, valid in the same cycle as imem_addr.
- halt  input  1  when high, no new line is fetched and the PC holds.
- redirect_valid  input  1  branch/mispredict redirect request.
- redirect_pc  input  AW  new fetch address, sampled when redirect_valid is high.
- out_valid  output  1  head of the FIFO holds a valid line.
- out_ready  input  1  decode accepts the head line this cycle.
- out_line  output  DW  head line data.
- out_pc  output  AW  line address of the head line.
- out_count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, takes effect immediately):
  - pc=RESET_PC, so imem_addr=RESET_PC.
  - wr_ptr=rd_ptr=0, count=0.
  - All storage entries cleared to 0, so out_line=0 and out_pc=0.
  - out_valid=0, out_count=0.
  - Reset asserted mid-operation discards all queued lines.
- Outputs:
  - imem_addr=pc, combinational from the register.
  - out_valid=(count!=0).
  - out_line and out_pc come from storage[rd_ptr]; no output register, so the head is visible with zero latency.
- pop = out_valid & out_ready.
- push = !redirect_valid & !halt & ((count<DEPTH) | pop).
  - A push into a full FIFO is allowed in the same cycle as a pop.
- On push:
  - storage[wr_ptr] <= {pc, imem_data}.
  - wr_ptr <= wr_ptr+1, modulo DEPTH.
  - pc <= pc+1 with wrap-around: 2^AW-1 goes to 0.
- On pop: rd_ptr <= rd_ptr+1, modulo DEPTH.
- count update: count <= count + push - pop. Push and pop together leave count unchanged.
- Fetch latency: a line addressed in cycle N is visible at out_line in cycle N+1 if the FIFO was empty.
- Redirect has priority over everything else:
  - In the redirect cycle: pc <= redirect_pc, wr_ptr=rd_ptr=0, count <= 0.
  - No push that cycle. Any pop that cycle is ignored for state purposes; decode must discard it.
  - out_valid=0 in the following cycle.
  - The first line from redirect_pc is pushed in the following cycle (unless halt is high) and is visible the cycle after that.
  - Redirect combined with halt still loads the PC and flushes.
- Halt:
  - PC and wr_ptr hold.
  - Pops continue, so the FIFO drains.
  - When halt deasserts, fetch resumes at the held PC.
- Full with no pop: no push, PC holds. imem_addr stays stable, so the same line is fetched again when space frees.
- Empty: out_valid=0, and out_ready is ignored.
- Storage: each entry is AW+DW bits.

Test Plan:
- Reset with RESET_PC=0, out_ready=1, no halt/redirect: imem_addr steps 0,1,2,3; out_pc steps 0,1,2 starting in cycle 1; out_line=mem[n]; out_count stays 1.
- out_ready=0 for 6 cycles after reset: out_count goes 1,2,3,4, then holds 4; imem_addr holds at 4. Then out_ready=1 for 1 cycle: out_pc=0 is popped, line 4 is pushed, and count stays 4.
- Fill to 4, then pulse redirect_valid with redirect_pc=0x0100: next cycle out_valid=0, out_count=0, imem_addr=0x0100; the cycle after, out_pc=0x0100 and out_line=mem[0x100].
- Set pc near the top via redirect_pc=0x3FFE, out_ready=1: out_pc sequence is 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Assert halt with 3 lines queued and out_ready=1: three pops, then out_valid=0 and imem_addr unchanged; deassert halt and fetch resumes at the held address.
- Assert rst asynchronously mid-stream (not on a clock edge): out_valid and out_count drop to 0 and imem_addr=RESET_PC immediately; after release, fetch restarts from RESET_PC.
